// File: rtl/sevenseg_scan_ctl.sv
// -----------------------------------------------------------------------------
// sevenseg_scan_ctl
// Time-multiplexed scan controller for an active-low 7-segment decoder.
// Holds NDIG 7-bit codes (bit6=blank, bit5=dp only, bit4=dash, else 0-15)
// and drives one digit per slot of DIV cycles. Each slot opens with BLANK_CYC
// cycles of all anodes off to suppress ghosting. New codes are staged by
// `load` and committed only at the frame boundary, so a frame never tears.
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   When defined, leading 7'd0 codes (from digit NDIG-1 downward, disabled
//   digits counting as zero) are shown as blank; digit 0 is never blanked.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      synchronous reset, active low
//   load       1-cycle strobe, captures digits_in / en_in into staging
//   digits_in  code for digit i at [7*i+6:7*i], digit 0 = rightmost
//   en_in      per-digit enable, captured with load
//   data_out   code to the decoder (registered)
//   an_n       anode enables, active low, at most one low (registered)
//   pending    staging holds an uncommitted load (registered)
//   frame_tick 1-cycle pulse on the first cycle of a new frame (registered)
// -----------------------------------------------------------------------------
module sevenseg_scan_ctl #(
    parameter int unsigned NDIG      = 8,
    parameter int unsigned DIV       = 100000,
    parameter int unsigned BLANK_CYC = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [7*NDIG-1:0]      digits_in,
    input  logic [NDIG-1:0]        en_in,
    output logic [6:0]             data_out,
    output logic [NDIG-1:0]        an_n,
    output logic                   pending,
    output logic                   frame_tick
);

    localparam int unsigned CNT_W = $clog2(DIV);
    localparam int unsigned IDX_W = $clog2(NDIG);

    localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK_LAST = CNT_W'((BLANK_CYC == 0) ? 0 : BLANK_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST       = IDX_W'(NDIG - 1);
    localparam logic [6:0]       CODE_BLANK     = 7'h40;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    // With no dead time every slot starts directly in DRIVE.
    localparam state_t ST_START = (BLANK_CYC == 0) ? ST_DRIVE : ST_BLANK;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [NDIG-1:0][6:0]     act_q, act_d;
    logic [NDIG-1:0][6:0]     stg_q, stg_d;
    logic [NDIG-1:0]          en_q, en_d;
    logic [NDIG-1:0]          en_stg_q, en_stg_d;
    logic                     pending_q, pending_d;
    logic [6:0]               data_q, data_d;
    logic [NDIG-1:0]          an_q, an_d;
    logic                     tick_q, tick_d;
    logic                     wrap;
    logic                     frame_end;

`ifdef LEADING_ZERO_BLANK_EN
    logic [NDIG-1:0]          lz_blank;
    logic                     zero_run;
`endif

    // State and datapath register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_START;
            cnt_q     <= '0;
            idx_q     <= '0;
            act_q     <= {NDIG{CODE_BLANK}};
            stg_q     <= {NDIG{CODE_BLANK}};
            en_q      <= '0;
            en_stg_q  <= '0;
            pending_q <= 1'b0;
            data_q    <= CODE_BLANK;
            an_q      <= '1;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            act_q     <= act_d;
            stg_q     <= stg_d;
            en_q      <= en_d;
            en_stg_q  <= en_stg_d;
            pending_q <= pending_d;
            data_q    <= data_d;
            an_q      <= an_d;
            tick_q    <= tick_d;
        end
    end

    // Next state: slot counter, digit index, BLANK/DRIVE phase, buffers
    always_comb begin
        wrap      = (cnt_q == CNT_LAST);
        frame_end = wrap && (idx_q == IDX_LAST);

        cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end

        state_d = state_q;
        case (state_q)
            ST_BLANK: if (cnt_q == CNT_BLANK_LAST) state_d = ST_DRIVE;
            ST_DRIVE: if (wrap) state_d = ST_START;
            default:  state_d = ST_START;
        endcase

        act_d     = act_q;
        en_d      = en_q;
        stg_d     = stg_q;
        en_stg_d  = en_stg_q;
        pending_d = pending_q;
        if (frame_end) begin
            // A load landing on the frame-end cycle bypasses staging.
            if (load) begin
                act_d = digits_in;
                en_d  = en_in;
            end else if (pending_q) begin
                act_d = stg_q;
                en_d  = en_stg_q;
            end
            pending_d = 1'b0;
        end else if (load) begin
            stg_d     = digits_in;
            en_stg_d  = en_in;
            pending_d = 1'b1;
        end
    end

    // Output decode from next-state values so the registered pins line up
    // with the current slot counter.
    always_comb begin
        data_d = CODE_BLANK;
        an_d   = '1;
        tick_d = frame_end;

`ifdef LEADING_ZERO_BLANK_EN
        lz_blank = '0;
        zero_run = 1'b1;
        for (int i = int'(NDIG) - 1; i > 0; i--) begin
            zero_run    = zero_run && (!en_d[i] || (act_d[i] == 7'd0));
            lz_blank[i] = zero_run;
        end
`endif

        if ((state_d == ST_DRIVE) && en_d[idx_d]) begin
            an_d[idx_d] = 1'b0;
            data_d      = act_d[idx_d];
`ifdef LEADING_ZERO_BLANK_EN
            if (lz_blank[idx_d]) data_d = CODE_BLANK;
`endif
        end
    end

    assign data_out   = data_q;
    assign an_n       = an_q;
    assign pending    = pending_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_sevenseg_scan_ctl.sv
// -----------------------------------------------------------------------------
// tb_sevenseg_scan_ctl
// Self-checking bench for sevenseg_scan_ctl (NDIG=4, DIV=8, BLANK_CYC=2).
// A reference model tracks the frame position as a single counter and the
// committed/staged buffers as arrays; every cycle the pins are compared to it.
// A vector table, hand-written corner sequences and random traffic drive it.
// -----------------------------------------------------------------------------
module tb_sevenseg_scan_ctl;

    localparam int NDIG      = 4;
    localparam int DIV       = 8;
    localparam int BLANK_CYC = 2;
    localparam int FRAME     = NDIG * DIV;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              load;
    logic [7*NDIG-1:0] digits_in;
    logic [NDIG-1:0]   en_in;
    logic [6:0]        data_out;
    logic [NDIG-1:0]   an_n;
    logic              pending;
    logic              frame_tick;

    always #5 clk = ~clk;

    sevenseg_scan_ctl #(
        .NDIG      (NDIG),
        .DIV       (DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .digits_in  (digits_in),
        .en_in      (en_in),
        .data_out   (data_out),
        .an_n       (an_n),
        .pending    (pending),
        .frame_tick (frame_tick)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int              mpos;
    logic [6:0]      m_act [NDIG];
    logic [6:0]      m_stg [NDIG];
    logic [NDIG-1:0] m_en;
    logic [NDIG-1:0] m_en_stg;
    bit              m_pend;
    bit              m_tick;

    typedef struct packed {
        logic [7*NDIG-1:0]    digits;
        logic [NDIG-1:0]      en;
        logic [NDIG-1:0][6:0] exp_data;  // per slot, slot 0 rightmost
        logic [NDIG-1:0][3:0] exp_an;
    } vec_t;

    vec_t tbl [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

`ifdef LEADING_ZERO_BLANK_EN
    // Digit d is blanked if it and every digit above it is zero or disabled.
    function automatic bit suppressed(input int d);
        if (d == 0) return 1'b0;
        for (int j = d; j < NDIG; j++) begin
            if (m_en[j] && (m_act[j] != 7'd0)) return 1'b0;
        end
        return 1'b1;
    endfunction
`endif

    // Advance the model across one rising edge using the applied inputs.
    task automatic model_edge();
        bit fe;
        if (!rst_n) begin
            mpos = 0;
            for (int i = 0; i < NDIG; i++) begin
                m_act[i] = 7'h40;
                m_stg[i] = 7'h40;
            end
            m_en     = '0;
            m_en_stg = '0;
            m_pend   = 1'b0;
            m_tick   = 1'b0;
        end else begin
            fe     = (mpos == FRAME - 1);
            m_tick = fe;
            if (fe) begin
                if (load) begin
                    for (int i = 0; i < NDIG; i++) m_act[i] = digits_in[7*i +: 7];
                    m_en = en_in;
                end else if (m_pend) begin
                    for (int i = 0; i < NDIG; i++) m_act[i] = m_stg[i];
                    m_en = m_en_stg;
                end
                m_pend = 1'b0;
            end else if (load) begin
                for (int i = 0; i < NDIG; i++) m_stg[i] = digits_in[7*i +: 7];
                m_en_stg = en_in;
                m_pend   = 1'b1;
            end
            mpos = (mpos + 1) % FRAME;
        end
    endtask

    // One clock: update model, then compare all pins after the edge.
    task automatic step();
        logic [3:0] ea;
        logic [3:0] one;
        logic [6:0] ed;
        int d;
        int c;
        @(posedge clk);
        model_edge();
        #1;
        d  = mpos / DIV;
        c  = mpos % DIV;
        ea = 4'hF;
        ed = 7'h40;
        if ((c >= BLANK_CYC) && m_en[d]) begin
            one = 4'b0001 << d;
            ea  = ~one;
            ed  = m_act[d];
`ifdef LEADING_ZERO_BLANK_EN
            if (suppressed(d)) ed = 7'h40;
`endif
        end
        check("an_n",       32'(an_n),       32'(ea));
        check("data_out",   32'(data_out),   32'(ed));
        check("pending",    32'(pending),    32'(m_pend));
        check("frame_tick", 32'(frame_tick), 32'(m_tick));
    endtask

    task automatic run_to_pos(input int target);
        for (int n = 0; (n < 2 * FRAME) && (mpos != target); n++) step();
    endtask

    // Step until the DUT raises frame_tick, bounded to two frames.
    task automatic wait_tick();
        int n;
        n = 0;
        while ((frame_tick !== 1'b1) && (n < 2 * FRAME)) begin
            step();
            n++;
        end
        check("tick_seen", 32'(frame_tick), 32'd1);
    endtask

    task automatic pulse_load(input logic [7*NDIG-1:0] d, input logic [NDIG-1:0] e);
        digits_in = d;
        en_in     = e;
        load      = 1'b1;
        step();
        load      = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1);
    end

    initial begin
        logic [6:0] code;

        tbl[0] = '{digits: {7'd1, 7'd2, 7'd3, 7'd4}, en: 4'b1111,
                   exp_data: {7'd1, 7'd2, 7'd3, 7'd4},
                   exp_an: {4'b0111, 4'b1011, 4'b1101, 4'b1110}};
        tbl[1] = '{digits: {7'd1, 7'd2, 7'd3, 7'd4}, en: 4'b0101,
                   exp_data: {7'h40, 7'd2, 7'h40, 7'd4},
                   exp_an: {4'b1111, 4'b1011, 4'b1111, 4'b1110}};
`ifdef LEADING_ZERO_BLANK_EN
        tbl[2] = '{digits: {7'd0, 7'd0, 7'd5, 7'd0}, en: 4'b1111,
                   exp_data: {7'h40, 7'h40, 7'd5, 7'd0},
                   exp_an: {4'b0111, 4'b1011, 4'b1101, 4'b1110}};
`else
        tbl[2] = '{digits: {7'd0, 7'd0, 7'd5, 7'd0}, en: 4'b1111,
                   exp_data: {7'd0, 7'd0, 7'd5, 7'd0},
                   exp_an: {4'b0111, 4'b1011, 4'b1101, 4'b1110}};
`endif
        tbl[3] = '{digits: {7'h40, 7'h20, 7'h10, 7'h0F}, en: 4'b1111,
                   exp_data: {7'h40, 7'h20, 7'h10, 7'h0F},
                   exp_an: {4'b0111, 4'b1011, 4'b1101, 4'b1110}};

        rst_n     = 1'b0;
        load      = 1'b0;
        digits_in = '0;
        en_in     = '0;
        repeat (3) step();
        check("reset_an",   32'(an_n),     32'hF);
        check("reset_data", 32'(data_out), 32'h40);
        rst_n = 1'b1;

        // Table: load mid-frame, then check one whole committed frame.
        for (int v = 0; v < 4; v++) begin
            run_to_pos(10);
            pulse_load(tbl[v].digits, tbl[v].en);
            check("tbl_pending_set", 32'(pending), 32'd1);
            wait_tick();
            check("tbl_pending_clr", 32'(pending), 32'd0);
            for (int k = 0; k < FRAME; k++) begin
                if (k > 0) step();
                if ((k % DIV) == 0)
                    check("tbl_dead_an", 32'(an_n), 32'hF);
                if ((k % DIV) == BLANK_CYC) begin
                    check("tbl_an",   32'(an_n),     32'(tbl[v].exp_an[k / DIV]));
                    check("tbl_data", 32'(data_out), 32'(tbl[v].exp_data[k / DIV]));
                end
            end
            step();
            check("tbl_frame_period", 32'(frame_tick), 32'd1);
        end

        // Mid-frame load must not tear the frame in progress.
        run_to_pos(10);
        pulse_load({7'd1, 7'd2, 7'd3, 7'd4}, 4'b1111);
        wait_tick();
        run_to_pos(DIV + 1);
        pulse_load({7'd9, 7'd9, 7'd9, 7'd9}, 4'b1111);
        run_to_pos(3 * DIV + BLANK_CYC);
        check("midload_old_data", 32'(data_out), 32'd1);
        check("midload_old_an",   32'(an_n),     32'b0111);
        check("midload_pending",  32'(pending),  32'd1);
        wait_tick();
        run_to_pos(BLANK_CYC);
        check("midload_new_data", 32'(data_out), 32'd9);

        // Load on the exact frame-end cycle commits straight to active.
        run_to_pos(FRAME - 1);
        check("coinc_pre_pending", 32'(pending), 32'd0);
        pulse_load({7'd15, 7'd12, 7'd11, 7'd10}, 4'b1111);
        check("coinc_tick",    32'(frame_tick), 32'd1);
        check("coinc_pending", 32'(pending),    32'd0);
        run_to_pos(BLANK_CYC);
        check("coinc_d0", 32'(data_out), 32'd10);
        run_to_pos(3 * DIV + BLANK_CYC);
        check("coinc_d3", 32'(data_out), 32'd15);

        // Reset mid-scan with a staged load pending: everything discarded.
        run_to_pos(13);
        pulse_load({7'd3, 7'd3, 7'd3, 7'd3}, 4'b1111);
        check("rst_pre_pending", 32'(pending), 32'd1);
        rst_n = 1'b0;
        for (int r = 0; r < 5; r++) begin
            step();
            check("rst_an",      32'(an_n),       32'hF);
            check("rst_data",    32'(data_out),   32'h40);
            check("rst_pending", 32'(pending),    32'd0);
            check("rst_tick",    32'(frame_tick), 32'd0);
        end
        rst_n = 1'b1;
        wait_tick();
        run_to_pos(BLANK_CYC);
        check("rst_no_commit_an", 32'(an_n), 32'hF);

        // Random traffic against the model.
        for (int n = 0; n < 800; n++) begin
            load  = ($urandom_range(0, 11) == 0);
            en_in = 4'($urandom_range(0, 15));
            for (int d = 0; d < NDIG; d++) begin
                code = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(0, 127));
                digits_in[7*d +: 7] = code;
            end
            rst_n = ($urandom_range(0, 299) != 0);
            step();
        end
        rst_n = 1'b1;
        load  = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
